filter_window_gen: RTL
======================

Name: filter_window_gen

Overview:
- Parametrised sliding-window generator for the Y channel. Next generation of the fixed 5x5 line-buffer/align path.
- Takes a raster stream (vs/hs/de plus pixel), keeps KSIZE-1 line buffers, and emits a full KSIZE x KSIZE window every active cycle on a flattened bus.
- Feeds any filter_conv_NxN core directly.
- Adds two things the 5x5 path lacks: a runtime border mode (valid-only or zero-pad) and line-overflow detection.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- KSIZE, 5, window edge length. Legal range 2..7.
- MAX_W, 1920, maximum active pixels per line; this is the line-buffer depth.
- ADDR_WIDTH, 12, column counter and line-buffer address width. Must satisfy 2^ADDR_WIDTH > MAX_W.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_mode  in  1  border mode: 0 = valid-only, 1 = zero-pad. Sampled at each i_vs rising edge.
- i_vs  in  1  vertical sync, active high.
- i_hs  in  1  horizontal sync, active high.
- i_de  in  1  data enable, active high.
- i_y  in  DATA_WIDTH  input pixel.
- o_vs  out  1  i_vs delayed 1 cycle.
- o_hs  out  1  i_hs delayed 1 cycle.
- o_de  out  1  i_de delayed 1 cycle.
- o_valid  out  1  window qualifier (see Behaviour).
- o_win  out  KSIZE*KSIZE*DATA_WIDTH  window. Element (r,c) occupies bits [(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH].
- o_ovf  out  1  sticky line-overflow flag, cleared at frame start.

Behaviour:
- Reset: every output, counter, shift register and mode latch is 0. Line-buffer contents are don't-care; output gating makes them unobservable.
- Window orientation:
  - Row r=0 is the oldest line; c=0 is the oldest column.
  - Element (KSIZE-1, KSIZE-1) is the current input pixel.
  - Row KSIZE-1 comes from i_y. Row KSIZE-2 comes from line buffer 0 (previous line), and so on up the chain.
- Latency: the window whose newest pixel is accepted at edge t appears on o_win/o_valid after edge t+1, aligned with o_vs/o_hs/o_de. Sync signals pass through a single register stage with no other modification.
- Column counter col:
  - Increments on each i_de cycle.
  - Resets to 0 on the first cycle where i_de=0 after i_de=1 (line end).
- Row counter row:
  - Increments at each line end, saturating at KSIZE-1.
  - Cleared, and i_mode latched, on the i_vs rising edge (i_vs=1 with previous i_vs=0).
  - A vs edge coinciding with a line end: clear wins.
- Line buffers:
  - KSIZE-1 single-port-per-cycle memories, depth MAX_W, read-before-write at address col.
  - Buffer k writes the value read from buffer k-1 (buffer 0 writes i_y). Writes occur only when i_de=1 and col < MAX_W.
- Horizontal shift: each row's KSIZE-tap shift register shifts only when i_de=1 and col < MAX_W. It holds otherwise.
- Overflow:
  - Pixels with col >= MAX_W are dropped: no write, no shift, col stops at MAX_W.
  - o_ovf sets on the first dropped pixel and stays 1 until the next i_vs rising edge.
  - o_de still follows i_de. o_valid=0 for dropped pixels.
- Mode 0 (valid-only): o_valid = de_d AND (row == KSIZE-1) AND (col_d >= KSIZE-1), where col_d is the pre-increment col of that pixel. o_win is passed unmasked.
- Mode 1 (zero-pad):
  - o_valid = de_d for every non-dropped pixel.
  - Element (r,c) is forced to 0 when r < KSIZE-1-row OR c < KSIZE-1-col_d. This masks stale data from prior lines or frames.
- i_mode changes mid-frame take effect only at the next vs rising edge.
- Reset mid-frame: state returns to reset values immediately. The first frame after reset follows the same rules as a fresh frame (row=0, mode from latched value 0 until the next vs edge).

Test Plan:
- KSIZE=3, MAX_W=8, mode 0, 4 lines x 6 px, pixel = 16*line+col. First o_valid is on line 2, col 2. o_win = {00,01,02,10,11,12,20,21,22} hex, r-major. There are 4 valid windows per line on lines 2–3. o_de has 1-cycle latency.
- Same stream in mode 1 (latched at vs): line 0 col 0 gives o_valid=1 and o_win all zero except element (2,2)=0x00. Line 1 col 1 gives elements (0,*) = 0 and (1,1)=0x00, (1,2)=0x01, (2,1)=0x10, (2,2)=0x11.
- Overflow: MAX_W=8, 10-px line. o_ovf rises on the cycle after pixel 8, o_valid=0 for pixels 8–9, the next line is unaffected, and o_ovf clears after the next vs edge.
- Frame restart: a 2-line frame, then vs, then a new frame with mode 1. No element from the previous frame appears unmasked on line 0 or line 1 of the new frame.
- Async reset asserted mid-line (col=4): all outputs go to 0 without a clock edge. After release, the next frame matches the first scenario's results exactly.
- KSIZE=7, MAX_W=16, mode 0, 8 lines x 10 px: the first o_valid is at line 6, col 6, and the center element (3,3) equals 16*3+3 = 0x33.

Source files
------------

// File: rtl/filter_window_gen.sv
// KSIZE x KSIZE sliding-window generator for a raster Y stream. It keeps KSIZE-1
// line buffers, supports valid-only or zero-pad borders, and flags line overflow.

module filter_window_lb #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_W      = 1920,
  parameter int LB_AW      = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LB_AW-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [MAX_W];

  // Asynchronous read: rdata holds the previous line's pixel at this column
  // in the same cycle the new pixel overwrites it.
  assign rdata = mem[addr];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
endmodule

module filter_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int KSIZE      = 5,
  parameter int MAX_W      = 1920,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              i_mode,
  input  logic                              i_vs,
  input  logic                              i_hs,
  input  logic                              i_de,
  input  logic [DATA_WIDTH-1:0]             i_y,
  output logic                              o_vs,
  output logic                              o_hs,
  output logic                              o_de,
  output logic                              o_valid,
  output logic [KSIZE*KSIZE*DATA_WIDTH-1:0] o_win,
  output logic                              o_ovf
);
  localparam int RW    = $clog2(KSIZE);
  localparam int LB_AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [RW-1:0]         ROW_MAX = RW'(KSIZE-1);
  localparam logic [ADDR_WIDTH-1:0] COL_LIM = ADDR_WIDTH'(MAX_W);
  localparam logic [ADDR_WIDTH-1:0] COL_KM1 = ADDR_WIDTH'(KSIZE-1);

  logic [ADDR_WIDTH-1:0] col, col_q;
  logic [RW-1:0]         row, row_q;
  logic                  mode, pad_q;

  logic [KSIZE-1:0][KSIZE-1:0][DATA_WIDTH-1:0] taps;   // [r][c]
  logic [KSIZE-1:0][DATA_WIDTH-1:0]            col_in;
  logic [KSIZE-2:0][DATA_WIDTH-1:0]            lb_rd, lb_wr;
  logic [LB_AW-1:0]                            lb_addr;

  logic vs_rise, line_end, in_range, pix_acc, drop;

  assign vs_rise  = i_vs & ~o_vs;
  assign line_end = o_de & ~i_de;
  assign in_range = col < COL_LIM;
  assign pix_acc  = i_de & in_range;
  assign drop     = i_de & ~in_range;
  assign lb_addr  = in_range ? LB_AW'(col) : '0;

  assign col_in[KSIZE-1] = i_y;

  for (genvar k = 0; k < KSIZE-1; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_wr[k] = i_y;
    end else begin : g_chain
      assign lb_wr[k] = lb_rd[k-1];
    end
    assign col_in[KSIZE-2-k] = lb_rd[k];

    filter_window_lb #(
      .DATA_WIDTH(DATA_WIDTH),
      .MAX_W     (MAX_W),
      .LB_AW     (LB_AW)
    ) u_lb (
      .clk  (clk),
      .we   (pix_acc),
      .addr (lb_addr),
      .wdata(lb_wr[k]),
      .rdata(lb_rd[k])
    );
  end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      o_vs    <= 1'b0;
      o_hs    <= 1'b0;
      o_de    <= 1'b0;
      o_valid <= 1'b0;
      o_ovf   <= 1'b0;
      col     <= '0;
      row     <= '0;
      mode    <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      pad_q   <= 1'b0;
    end else begin
      o_vs <= i_vs;
      o_hs <= i_hs;
      o_de <= i_de;

      if (line_end)     col <= '0;
      else if (pix_acc) col <= col + 1'b1;

      if (vs_rise) begin
        row  <= '0;
        mode <= i_mode;
      end else if (line_end && row != ROW_MAX) begin
        row <= row + 1'b1;
      end

      if (drop)         o_ovf <= 1'b1;
      else if (vs_rise) o_ovf <= 1'b0;

      o_valid <= pix_acc & (mode | ((row == ROW_MAX) & (col >= COL_KM1)));

      // Mask context travels with the taps so o_win stays self-consistent while held.
      if (pix_acc) begin
        row_q <= row;
        col_q <= col;
        pad_q <= mode;
      end
    end

  always_ff @(posedge clk or negedge rstn)
    if (!rstn)
      taps <= '0;
    else if (pix_acc)
      for (int r = 0; r < KSIZE; r++)
        taps[r] <= {col_in[r], taps[r][KSIZE-1:1]};

  always_comb begin
    o_win = '0;
    for (int r = 0; r < KSIZE; r++)
      for (int c = 0; c < KSIZE; c++)
        if (!(pad_q && ((r + int'(row_q) < KSIZE-1) || (c + int'(col_q) < KSIZE-1))))
          o_win[(r*KSIZE+c)*DATA_WIDTH +: DATA_WIDTH] = taps[r][c];
  end
endmodule
